// File: rtl/uart_pkg.sv
// Shared constants, encodings and helpers for the oversampling UART receiver.
package uart_pkg;

  localparam int unsigned OS_RATE    = 16;
  localparam int unsigned OS_CNT_W   = 4;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned SAMPLE_HI  = 9;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic [1:0] {
    PAR_SPACE = 2'b00,
    PAR_MARK  = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_ODD   = 2'b11
  } par_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  typedef struct packed {
    logic      data_size;
    logic      parity_en;
    par_mode_e parity_mode;
    logic      stop_bit_size;
  } cfg_t;

  // Parity bit value the transmitter should have sent for this word.
  function automatic logic parity_expected(input par_mode_e mode, input logic [DATA_W-1:0] word);
    logic p;
    case (mode)
      PAR_ODD:  p = ~(^word);
      PAR_EVEN: p = ^word;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Serial line, frame configuration and received-word bus of the UART receiver.
interface uart_rx_os_if;
  logic       rx;
  logic       data_size;
  logic       parity_en;
  logic [1:0] parity_mode;
  logic       stop_bit_size;
  logic [7:0] data;
  logic       new_data;
  logic       err_parity;
  logic       err_frame;
  logic       busy;

  modport master (
    output rx, data_size, parity_en, parity_mode, stop_bit_size,
    input  data, new_data, err_parity, err_frame, busy
  );

  modport slave (
    input  rx, data_size, parity_en, parity_mode, stop_bit_size,
    output data, new_data, err_parity, err_frame, busy
  );
endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one tick every OS_DIV clocks, realigned by restart.
module uart_os_tick #(
  parameter int unsigned OS_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c = (cnt == CNT_W'(OS_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap_c;
      cnt  <= wrap_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with 2-of-3 majority voting per bit,
// configurable word length, parity and stop bits.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned OS_DIV = 54
) (
  input logic         clk,
  input logic         rst,
  uart_rx_os_if.slave bus
);

  logic                rx_meta, rx_sync, rx_prev;
  logic                fall_c, restart_c, tick;
  state_e              state, state_nxt;
  logic [OS_CNT_W-1:0] os_cnt;
  logic [2:0]          bit_cnt;
  logic                s_lo, s_mid;
  cfg_t                cfg;
  logic [DATA_W-1:0]   shreg;
  logic                par_bit, stop_err;
  logic                maj_c, sample_c, bit_end_c, last_data_c, last_stop_c;
  logic                frame_done_c;
  logic [DATA_W-1:0]   word_c;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall_c    = rx_prev & ~rx_sync;
  assign restart_c = (state == S_IDLE) && fall_c;

  uart_os_tick #(.OS_DIV(OS_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick    (tick)
  );

  assign maj_c        = (s_lo & s_mid) | (s_lo & rx_sync) | (s_mid & rx_sync);
  assign sample_c     = tick && (os_cnt == OS_CNT_W'(SAMPLE_HI));
  assign bit_end_c    = tick && (os_cnt == OS_CNT_W'(OS_RATE - 1));
  assign last_data_c  = (bit_cnt == (cfg.data_size ? 3'd7 : 3'd6));
  assign last_stop_c  = (bit_cnt == 3'(cfg.stop_bit_size));
  assign frame_done_c = (state == S_STOP) && sample_c && last_stop_c;
  assign word_c       = cfg.data_size ? shreg : {1'b0, shreg[DATA_W-2:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (fall_c) state_nxt = S_START;
      S_START: begin
        if (sample_c && maj_c) state_nxt = S_IDLE;
        else if (bit_end_c)    state_nxt = S_DATA;
      end
      S_DATA:      if (bit_end_c && last_data_c) state_nxt = cfg.parity_en ? S_PARITY : S_STOP;
      S_PARITY:    if (bit_end_c) state_nxt = S_STOP;
      S_STOP:      if (frame_done_c) state_nxt = rx_sync ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_sync) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Bit timing, majority samples and frame accumulation; config frozen per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt   <= '0;
      bit_cnt  <= '0;
      s_lo     <= 1'b0;
      s_mid    <= 1'b0;
      cfg      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_err <= 1'b0;
    end else if (restart_c) begin
      os_cnt   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      stop_err <= 1'b0;
      cfg      <= '{data_size:     bus.data_size,
                    parity_en:     bus.parity_en,
                    parity_mode:   par_mode_e'(bus.parity_mode),
                    stop_bit_size: bus.stop_bit_size};
    end else if (tick && state != S_IDLE && state != S_WAIT_HIGH) begin
      os_cnt <= os_cnt + OS_CNT_W'(1);
      if (os_cnt == OS_CNT_W'(SAMPLE_LO))  s_lo  <= rx_sync;
      if (os_cnt == OS_CNT_W'(SAMPLE_MID)) s_mid <= rx_sync;
      if (sample_c) begin
        case (state)
          S_DATA:   shreg[bit_cnt] <= maj_c;
          S_PARITY: par_bit <= maj_c;
          S_STOP:   if (!maj_c) stop_err <= 1'b1;
          default:  ;
        endcase
      end
      if (bit_end_c)
        bit_cnt <= ((state == S_DATA && !last_data_c) || state == S_STOP) ? bit_cnt + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data       <= '0;
      bus.new_data   <= 1'b0;
      bus.err_parity <= 1'b0;
      bus.err_frame  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.new_data <= frame_done_c;
      bus.busy     <= (state_nxt != S_IDLE);
      if (frame_done_c) begin
        bus.data       <= word_c;
        bus.err_parity <= cfg.parity_en & (par_bit != parity_expected(cfg.parity_mode, word_c));
        bus.err_frame  <= stop_err | ~maj_c;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_os;

  localparam int unsigned OS_DIV  = 4;
  localparam int unsigned BIT_CYC = 16 * OS_DIV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_os_if bus ();

  uart_rx_os #(.OS_DIV(OS_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Observed frames: {err_parity, err_frame, data}.
  logic [9:0] cap_q[$];
  int         long_pulses = 0;
  logic       nd_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.new_data) cap_q.push_back({bus.err_parity, bus.err_frame, bus.data});
    if (bus.new_data && nd_prev) long_pulses <= long_pulses + 1;
    nd_prev <= bus.new_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int unsigned n);
    bus.rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: what the receiver must report for a transmitted frame.
  function automatic logic [9:0] model(input logic ds, input logic pen, input logic [1:0] pm,
                                       input logic sb, input logic [7:0] w, input logic pb,
                                       input logic [1:0] stops);
    logic [7:0] d;
    int         ones;
    logic       need, ep, ef;
    d    = ds ? w : (w & 8'h7F);
    ones = $countones(d);
    case (pm)
      2'b11:   need = (ones % 2 == 0);
      2'b10:   need = (ones % 2 == 1);
      2'b01:   need = 1'b1;
      default: need = 1'b0;
    endcase
    ep = pen && (pb != need);
    ef = (stops[0] == 1'b0) || (sb && stops[1] == 1'b0);
    return {ep, ef, d};
  endfunction

  // Drives one frame; config inputs are scrambled after the start bit.
  task automatic send_frame(input logic ds, input logic pen, input logic [1:0] pm, input logic sb,
                            input logic [7:0] w, input logic pb, input logic [1:0] stops,
                            output logic [9:0] exp);
    bus.data_size     = ds;
    bus.parity_en     = pen;
    bus.parity_mode   = pm;
    bus.stop_bit_size = sb;
    exp = model(ds, pen, pm, sb, w, pb, stops);
    hold(1'b0, BIT_CYC);
    bus.data_size     = 1'($urandom);
    bus.parity_en     = 1'($urandom);
    bus.parity_mode   = 2'($urandom);
    bus.stop_bit_size = 1'($urandom);
    for (int i = 0; i < (ds ? 8 : 7); i++) hold(w[i], BIT_CYC);
    if (pen) hold(pb, BIT_CYC);
    hold(stops[0], BIT_CYC);
    if (sb) hold(stops[1], BIT_CYC);
  endtask

  task automatic expect_frame(input string tag, input logic [9:0] exp);
    logic [9:0] got;
    got = 10'h3FF;
    if (cap_q.size() > 0) got = cap_q.pop_front();
    check({tag, "_data"}, 32'(got[7:0]), 32'(exp[7:0]));
    check({tag, "_err_frame"}, 32'(got[8]), 32'(exp[8]));
    check({tag, "_err_parity"}, 32'(got[9]), 32'(exp[9]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(bus.data), 32'h00);
    check({tag, "_new_data"}, 32'(bus.new_data), 32'h0);
    check({tag, "_err_parity"}, 32'(bus.err_parity), 32'h0);
    check({tag, "_err_frame"}, 32'(bus.err_frame), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    logic [9:0] e1, e2;
    logic       ds, pen, sb, pb;
    logic [1:0] pm, stops;
    logic [7:0] w;

    rst = 1'b1;
    bus.rx = 1'b1;
    bus.data_size = 1'b1;
    bus.parity_en = 1'b0;
    bus.parity_mode = 2'b00;
    bus.stop_bit_size = 1'b0;
    repeat (5) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    hold(1'b1, 2 * BIT_CYC);

    // 8N1 0xA5
    send_frame(1'b1, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b0, 2'b11, e1);
    hold(1'b1, BIT_CYC);
    #1 check("a5_count", 32'(cap_q.size()), 32'd1);
    expect_frame("a5", e1);
    check("a5_busy_idle", 32'(bus.busy), 32'h0);

    // 8O1 0xAA with wrong then correct parity bit
    send_frame(1'b1, 1'b1, 2'b11, 1'b0, 8'hAA, 1'b0, 2'b11, e1);
    hold(1'b1, BIT_CYC);
    #1 check("odd_bad_count", 32'(cap_q.size()), 32'd1);
    expect_frame("odd_bad", e1);
    send_frame(1'b1, 1'b1, 2'b11, 1'b0, 8'hAA, 1'b1, 2'b11, e1);
    hold(1'b1, BIT_CYC);
    #1 expect_frame("odd_good", e1);

    // 7E2 0x55, second stop bit low
    send_frame(1'b0, 1'b1, 2'b10, 1'b1, 8'h55, 1'b0, 2'b01, e1);
    hold(1'b1, 2 * BIT_CYC);
    #1 check("stop2_count", 32'(cap_q.size()), 32'd1);
    expect_frame("stop2", e1);

    // 5-tick glitch, then a valid frame
    hold(1'b0, 5 * OS_DIV);
    #1 check("glitch_busy_high", 32'(bus.busy), 32'h1);
    hold(1'b1, 2 * BIT_CYC);
    #1 check("glitch_busy_low", 32'(bus.busy), 32'h0);
    check("glitch_no_pulse", 32'(cap_q.size()), 32'd0);
    send_frame(1'b1, 1'b0, 2'b00, 1'b0, 8'h3C, 1'b0, 2'b11, e1);
    hold(1'b1, BIT_CYC);
    #1 expect_frame("after_glitch", e1);

    // Back-to-back 0x55, 0x81, then reset in the middle of a third frame
    send_frame(1'b1, 1'b0, 2'b00, 1'b0, 8'h55, 1'b0, 2'b11, e1);
    send_frame(1'b1, 1'b0, 2'b00, 1'b0, 8'h81, 1'b0, 2'b11, e2);
    bus.data_size = 1'b1;
    bus.parity_en = 1'b0;
    bus.stop_bit_size = 1'b0;
    hold(1'b0, BIT_CYC);
    hold(1'b1, BIT_CYC);
    hold(1'b0, 2 * BIT_CYC);
    #1 check("b2b_count", 32'(cap_q.size()), 32'd2);
    expect_frame("b2b_first", e1);
    expect_frame("b2b_second", e2);
    check("mid_frame_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    #1 check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 2 * BIT_CYC);
    #1 check("mid_rst_no_pulse", 32'(cap_q.size()), 32'd0);
    check_reset_outputs("post_rst");

    // Line held low for three frame times
    bus.data_size = 1'b1;
    bus.parity_en = 1'b0;
    bus.stop_bit_size = 1'b0;
    hold(1'b0, 3 * 10 * BIT_CYC);
    #1 check("break_count", 32'(cap_q.size()), 32'd1);
    expect_frame("break", {1'b0, 1'b1, 8'h00});
    check("break_busy", 32'(bus.busy), 32'h1);
    hold(1'b1, 2 * BIT_CYC);
    #1 check("break_release_busy", 32'(bus.busy), 32'h0);
    check("break_no_more", 32'(cap_q.size()), 32'd0);

    // Randomized frames
    for (int n = 0; n < 10; n++) begin
      ds    = 1'($urandom);
      pen   = 1'($urandom);
      pm    = 2'($urandom);
      sb    = 1'($urandom);
      w     = 8'($urandom);
      pb    = 1'($urandom);
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send_frame(ds, pen, pm, sb, w, pb, stops, e1);
      hold(1'b1, BIT_CYC + 32'($urandom_range(0, BIT_CYC)));
      #1 check("rand_count", 32'(cap_q.size()), 32'd1);
      expect_frame("rand", e1);
      check("rand_busy", 32'(bus.busy), 32'h0);
    end

    check("pulse_width", 32'(long_pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The block SHALL take parameter OS_DIV, default 54, giving the number of clk cycles per 1/16-bit oversample tick (100 MHz to 115200 baud x16).
REQ-002 The block SHALL have a single clock and a reset that is synchronous and active-high.
REQ-003 Port: clk  in  1  system clock, all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: rx  in  1  asynchronous serial line, idle high.
REQ-006 Port: data_size  in  1  0: 7 data bits; 1: 8 data bits.
REQ-007 Port: parity_en  in  1  1: parity bit present after data.
REQ-008 Port: parity_mode  in  2  11 odd, 10 even, 01 mark (1), 00 space (0).
REQ-009 Port: stop_bit_size  in  1  0: one stop bit; 1: two stop bits.
REQ-010 Port: data  out  8  last received word, LSB first on line; bit 7 = 0 in 7-bit mode.
REQ-011 Port: new_data  out  1  one-cycle pulse when data/err_* update.
REQ-012 Port: err_parity  out  1  parity mismatch on last frame.
REQ-013 Port: err_frame  out  1  a stop bit was sampled low on last frame.
REQ-014 Port: busy  out  1  high from start-bit detection until return to IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-016 The tick counter SHALL count 0..OS_DIV-1, emit one tick per wrap, and restart at 0 on start-bit detection.
REQ-017 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-018 IDLE->START SHALL occur on a synchronized high-to-low transition; data_size, parity_en, parity_mode and stop_bit_size are latched at that cycle.
REQ-019 Each bit SHALL span 16 ticks, with its value the 2-of-3 majority of the samples at ticks 7, 8 and 9.
REQ-020 In START, a majority-high result SHALL be treated as a glitch: return to IDLE, no new_data, busy drops.
REQ-021 DATA SHALL shift 7 or 8 bits LSB first, then go to PARITY if parity_en, else STOP.
REQ-022 PARITY expected value SHALL be: odd -> XOR of data bits inverted; even -> XOR of data bits; mark 1; space 0. Mismatch sets err_parity.
REQ-023 STOP SHALL sample 1 or 2 stop bits; any low sample sets err_frame.
REQ-024 At the tick-9 sample of the final stop bit, data, err_parity and err_frame SHALL update and new_data SHALL pulse for exactly one clk on the next cycle.
REQ-025 After that update the FSM SHALL go to IDLE if rx is high, so a back-to-back start bit is detectable half a bit later; if rx is low it goes to WAIT_HIGH.
REQ-026 WAIT_HIGH (break / line held low) SHALL stay until synchronized rx is high, then go to IDLE; no further frames are reported until then.
REQ-027 data and err_* SHALL hold their values until the next new_data; err_parity SHALL be 0 when the latched parity_en is 0.
REQ-028 Configuration input changes mid-frame SHALL have no effect until the next start detection.

Reset
REQ-029 On rst: FSM=IDLE, counters=0, synchronizer flops=1, data=8'h00, new_data=0, err_parity=0, err_frame=0, busy=0.
REQ-030 rst asserted mid-frame SHALL abort the frame with no new_data pulse; reception resumes on the first falling edge after rst deasserts.

Structure
REQ-031 Package uart_pkg SHALL hold the parity_mode encodings, the FSM state encoding, and the oversample constants (16, sample ticks 7/8/9).
REQ-032 The tick generator SHALL be sub-module uart_os_tick (clk, rst, restart, tick), parameterized by OS_DIV.

Verification
REQ-033 8 bits, parity off, 1 stop, rx sends 8'hA5 -> one new_data, data=8'hA5, both errors 0.
REQ-034 8 bits, odd parity, 8'hAA with parity bit 0 -> data=8'hAA, err_parity=1; repeat with parity bit 1 -> err_parity=0.
REQ-035 7 bits, even parity, 2 stop, 7'h55 with second stop bit low -> data=8'h55, err_frame=1.
REQ-036 rx low pulse of 5 ticks -> no new_data, busy returns 0, next valid frame 8'h3C received correctly.
REQ-037 Frames 8'h55 then 8'h81 back-to-back with one stop bit -> two new_data pulses, both correct; rst asserted mid-third frame -> no pulse, all outputs at reset values.
REQ-038 rx held low for 3 frame times -> single new_data with err_frame=1 and data=8'h00, then none until rx goes high.
